// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared constants, state encoding and lookup helpers for the
//               score panel.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam logic [7:0] BLANK_CODE = 8'h0f;
    localparam logic [7:0] DIGIT_BASE = 8'h00;
    localparam int         LABEL_LEN  = 7;

    // Left-most byte is column 0
    localparam logic [8*LABEL_LEN-1:0] LABEL_TEXT = {BLANK_CODE, "POGGY", BLANK_CODE};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2
    } score_state_t;

    function automatic logic [7:0] label_char(input int col);
        if (col >= 0 && col < LABEL_LEN)
            return LABEL_TEXT[8*(LABEL_LEN-1-col) +: 8];
        return BLANK_CODE;
    endfunction

    // Points awarded per line-clear count, packed BCD (up to 8 digits)
    function automatic logic [31:0] points_bcd(input logic [2:0] lines);
        case (lines)
            3'd1:    return 32'h0000_0040;
            3'd2:    return 32'h0000_0100;
            3'd3:    return 32'h0000_0300;
            3'd4:    return 32'h0000_1200;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_panel_if.sv
`default_nettype none
// ============================================================================
// Module      : score_panel_if
// Description : Event handshake and character read port of the score panel.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_panel_if #(
    parameter int ADDR_W = 6
);
    logic              add_valid;
    logic [2:0]        add_lines;
    logic              add_ready;
    logic              clear;
    logic              done;
    logic [ADDR_W-1:0] char_addr;
    logic [7:0]        char_data;

    modport master (
        output add_valid, add_lines, clear, char_addr,
        input  add_ready, done, char_data
    );

    modport slave (
        input  add_valid, add_lines, clear, char_addr,
        output add_ready, done, char_data
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : Single BCD digit adder with carry in/out (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] w_raw;

    always_comb begin
        w_raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
        if (w_raw > 5'd9) begin
            sum_o  = 4'(w_raw - 5'd10);
            cout_o = 1'b1;
        end else begin
            sum_o  = w_raw[3:0];
            cout_o = 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/score_panel.sv
`default_nettype none
// ============================================================================
// Module      : score_panel
// Description : Live BCD score / high score keeper serving character codes
//               for a COLS x ROWS text panel.
// Revision    : 1.0 - initial release
// ============================================================================
module score_panel
    import score_pkg::*;
#(
    parameter int COLS      = 7,
    parameter int ROWS      = 6,
    parameter int DIGITS    = 5,
    parameter int SCORE_ROW = 1,
    parameter int HI_ROW    = 4,
    parameter int SCORE_COL = 1,
    parameter int LABEL_ROW = 3,
    parameter int LZB       = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    score_panel_if.slave     bus
);
    localparam int SW     = 4 * DIGITS;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int S_BASE = SCORE_ROW * COLS + SCORE_COL;
    localparam int H_BASE = HI_ROW * COLS + SCORE_COL;
    localparam int L_BASE = LABEL_ROW * COLS;

    score_state_t     state_q;
    logic [SW-1:0]    score_q, hi_q, work_q, addend_q;
    logic             carry_q, done_q, ready_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       char_q, char_d;

    logic [3:0]       w_sum;
    logic             w_cout;
    logic [SW-1:0]    w_final;
    logic [7:0]       w_score_ch [DIGITS];
    logic [7:0]       w_hi_ch    [DIGITS];

    bcd_digit_add u_add (
        .a_i    (work_q[4*idx_q +: 4]),
        .b_i    (addend_q[4*idx_q +: 4]),
        .cin_i  (carry_q),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // Carry out of the MSD means overflow: clamp to all nines
    assign w_final = carry_q ? {DIGITS{4'h9}} : work_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            score_q  <= '0;
            hi_q     <= '0;
            work_q   <= '0;
            addend_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                score_q <= '0;
                state_q <= IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (bus.add_valid) begin
                        work_q   <= score_q;
                        addend_q <= SW'(points_bcd(bus.add_lines));
                        carry_q  <= 1'b0;
                        idx_q    <= '0;
                        state_q  <= ADD;
                        ready_q  <= 1'b0;
                    end
                    ADD: begin
                        work_q[4*idx_q +: 4] <= w_sum;
                        carry_q <= w_cout;
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(DIGITS-1))
                            state_q <= COMMIT;
                    end
                    COMMIT: begin
                        score_q <= w_final;
                        if (w_final > hi_q)
                            hi_q <= w_final;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Digit glyphs, MSD-first leading-zero run blanked; the LSD is never blanked
    always_comb begin
        logic lz_s, lz_h;
        logic [3:0] ds, dh;
        lz_s = 1'b1;
        lz_h = 1'b1;
        ds   = '0;
        dh   = '0;
        for (int j = DIGITS-1; j >= 0; j--) begin
            ds   = score_q[4*j +: 4];
            dh   = hi_q[4*j +: 4];
            lz_s = lz_s && (ds == 4'd0) && (j != 0);
            lz_h = lz_h && (dh == 4'd0) && (j != 0);
            w_score_ch[j] = (LZB != 0 && lz_s) ? BLANK_CODE : DIGIT_BASE + {4'b0000, ds};
            w_hi_ch[j]    = (LZB != 0 && lz_h) ? BLANK_CODE : DIGIT_BASE + {4'b0000, dh};
        end
    end

    always_comb begin
        int a;
        a      = int'(bus.char_addr);
        char_d = BLANK_CODE;
        for (int p = 0; p < DIGITS; p++) begin
            if (a == S_BASE + p) char_d = w_score_ch[DIGITS-1-p];
            if (a == H_BASE + p) char_d = w_hi_ch[DIGITS-1-p];
        end
        for (int c = 0; c < COLS; c++) begin
            if (a == L_BASE + c) char_d = label_char(c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) char_q <= BLANK_CODE;
        else        char_q <= char_d;
    end

    assign bus.add_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.char_data = char_q;

endmodule
`default_nettype wire

// File: tb/tb_score_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_panel
// Description : Directed self-checking bench for score_panel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_panel;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_panel_if #(.ADDR_W(6)) bus ();

    score_panel #(
        .COLS(7), .ROWS(6), .DIGITS(5), .SCORE_ROW(1), .HI_ROW(4),
        .SCORE_COL(1), .LABEL_ROW(3), .LZB(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_score = 0;
    int m_hi = 0;
    logic [7:0] lbl [7] = '{8'h0f, 8'h50, 8'h4f, 8'h47, 8'h47, 8'h59, 8'h0f};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input int addr, input int sc, input int hi);
        int row, col, val, pos, pw;
        if (addr >= 42) return 8'h0f;
        row = addr / 7;
        col = addr % 7;
        if (row == 3) return lbl[col];
        if ((row == 1 || row == 4) && col >= 1 && col <= 5) begin
            val = (row == 1) ? sc : hi;
            pos = col - 1;
            pw  = 1;
            for (int k = 0; k < 4 - pos; k++) pw *= 10;
            if (pos < 4 && val < pw) return 8'h0f;
            return 8'((val / pw) % 10);
        end
        return 8'h0f;
    endfunction

    task automatic rd_cell(input int addr, input logic [7:0] exp, input string tag);
        bus.char_addr = 6'(addr);
        tick();
        chk($sformatf("%s_cell%0d", tag, addr), {24'h0, bus.char_data}, {24'h0, exp});
    endtask

    task automatic check_panel(input string tag);
        for (int a = 0; a < 42; a++)
            rd_cell(a, exp_char(a, m_score, m_hi), tag);
    endtask

    function automatic int pts(input int lines);
        case (lines)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return 1200;
            default: return 0;
        endcase
    endfunction

    // ADD_VALID held high until DONE is seen
    task automatic add_held(input int lines);
        int lat, rl;
        bus.add_valid = 1'b1;
        bus.add_lines = 3'(lines);
        tick();
        lat = 0;
        rl  = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.add_ready === 1'b0) rl++;
            tick();
            lat++;
        end
        bus.add_valid = 1'b0;
        chk("latency", lat, 6);
        chk("ready_low_cycles", rl, 6);
        chk("ready_at_done", {31'h0, bus.add_ready}, 1);
        m_score = m_score + pts(lines);
        if (m_score > 99999) m_score = 99999;
        if (m_score > m_hi) m_hi = m_score;
        tick();
        chk("done_pulse_width", {31'h0, bus.done}, 0);
    endtask

    task automatic clear_score();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_score = 0;
        chk("clear_no_done", {31'h0, bus.done}, 0);
    endtask

    task automatic watch_no_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk(tag, {31'h0, seen}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_lines = 3'd0;
        bus.clear     = 1'b0;
        bus.char_addr = 6'd0;
        tick();
        tick();
        chk("rst_ready", {31'h0, bus.add_ready}, 1);
        chk("rst_done", {31'h0, bus.done}, 0);
        chk("rst_char", {24'h0, bus.char_data}, 32'h0f);
        rst_n = 1'b1;
        tick();
        check_panel("reset");

        add_held(1);
        check_panel("add40");

        clear_score();
        check_panel("clr40");
        add_held(4);
        check_panel("s1200");
        add_held(4);
        check_panel("s2400");
        add_held(3);
        check_panel("s2700");

        add_held(0);
        add_held(7);
        rd_cell(12, exp_char(12, m_score, m_hi), "nopts");

        clear_score();
        for (int i = 0; i < 82; i++) add_held(4);
        add_held(3);
        add_held(3);
        check_panel("s99000");
        add_held(4);
        check_panel("sat");

        // CLEAR during the third ADD cycle
        bus.add_valid = 1'b1;
        bus.add_lines = 3'd1;
        tick();
        bus.add_valid = 1'b0;
        tick();
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        m_score = 0;
        chk("abort_ready", {31'h0, bus.add_ready}, 1);
        chk("abort_done", {31'h0, bus.done}, 0);
        watch_no_done("abort_no_done");
        check_panel("abort");

        // CLEAR and offered event in the same cycle
        bus.add_valid = 1'b1;
        bus.add_lines = 3'd4;
        bus.clear     = 1'b1;
        tick();
        bus.add_valid = 1'b0;
        bus.clear     = 1'b0;
        chk("clrwin_ready", {31'h0, bus.add_ready}, 1);
        watch_no_done("clrwin_no_done");
        rd_cell(12, exp_char(12, m_score, m_hi), "clrwin");

        for (int a = 42; a < 64; a++) rd_cell(a, 8'h0f, "oob");

        add_held(2);
        bus.add_valid = 1'b1;
        bus.add_lines = 3'd1;
        tick();
        bus.add_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'h0, bus.add_ready}, 1);
        chk("midrst_done", {31'h0, bus.done}, 0);
        chk("midrst_char", {24'h0, bus.char_data}, 32'h0f);
        tick();
        rst_n = 1'b1;
        m_score = 0;
        m_hi    = 0;
        watch_no_done("midrst_no_done");
        check_panel("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
